// File: rtl/apb_arb_master.sv
// apb_arb_master: round-robin arbiter and APB master for two requesters
// sharing one 8-bit APB register bus. One transfer is outstanding at a time.
// Each transfer runs SETUP -> ACCESS, and every output is registered.
// Optional feature (define APB_TIMEOUT_EN): ACCESS is force-terminated with
// err=1 after TIMEOUT_CYCLES wait cycles with pready low.
module apb_arb_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_nxt;

  // The APB output registers double as the request latch. They are loaded
  // at grant and held until completion, so later changes on reqN_* are ignored.
  logic              last_grant, last_grant_nxt;
  logic              grant_id, grant_id_nxt;
  logic              psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt;
  logic              done0_nxt, done1_nxt, err0_nxt, err1_nxt;
  logic [DATA_W-1:0] rdata0_nxt, rdata1_nxt;

  // A requester stays ineligible for the cycle in which it sees done.
  // That rule, together with the IDLE state, gives the mandatory IDLE gap.
  logic elig0, elig1, any_req, pick;
  logic timeout_hit, complete;
  logic              cpl_err;
  logic [DATA_W-1:0] cpl_rdata;

  assign elig0   = req0_valid & ~req0_done;
  assign elig1   = req1_valid & ~req1_done;
  assign any_req = elig0 | elig1;
  // On a tie, grant the requester that was not served last.
  assign pick    = (elig0 & elig1) ? ~last_grant : elig1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_arb_master: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Count the ACCESS cycles spent with pready low. The counter is zero
  // whenever the FSM is outside ACCESS.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      wait_cnt <= '0;
    end else if (state != ACCESS) begin
      wait_cnt <= '0;
    end else if (!pready && (wait_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ACCESS) && !pready &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  assign complete  = (state == ACCESS) && (pready || timeout_hit);
  // A normal pready completion has priority over a timeout in the same cycle.
  assign cpl_err   = pready ? pslverr : 1'b1;
  assign cpl_rdata = pready ? prdata : '0;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: each always_comb assigns a default before any branch, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (complete) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, grant bookkeeping and completion status.
  always_comb begin
    last_grant_nxt = last_grant;
    grant_id_nxt   = grant_id;
    psel_nxt       = psel;
    penable_nxt    = penable;
    pwrite_nxt     = pwrite;
    paddr_nxt      = paddr;
    pwdata_nxt     = pwdata;
    done0_nxt      = 1'b0;
    done1_nxt      = 1'b0;
    err0_nxt       = req0_err;
    err1_nxt       = req1_err;
    rdata0_nxt     = req0_rdata;
    rdata1_nxt     = req1_rdata;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          grant_id_nxt   = pick;
          last_grant_nxt = pick;
          psel_nxt       = 1'b1;
          penable_nxt    = 1'b0;
          pwrite_nxt     = pick ? req1_write : req0_write;
          paddr_nxt      = pick ? req1_addr  : req0_addr;
          pwdata_nxt     = pick ? req1_wdata : req0_wdata;
        end
      end
      SETUP: penable_nxt = 1'b1;
      ACCESS: begin
        if (complete) begin
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          pwrite_nxt  = 1'b0;
          pwdata_nxt  = '0;
          if (grant_id) begin
            done1_nxt = 1'b1;
            err1_nxt  = cpl_err;
            if (!pwrite) rdata1_nxt = cpl_rdata;
          end else begin
            done0_nxt = 1'b1;
            err0_nxt  = cpl_err;
            if (!pwrite) rdata0_nxt = cpl_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  // Output and grant registers. last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_err   <= 1'b0;
      req1_err   <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      last_grant <= last_grant_nxt;
      grant_id   <= grant_id_nxt;
      psel       <= psel_nxt;
      penable    <= penable_nxt;
      pwrite     <= pwrite_nxt;
      paddr      <= paddr_nxt;
      pwdata     <= pwdata_nxt;
      req0_done  <= done0_nxt;
      req1_done  <= done1_nxt;
      req0_err   <= err0_nxt;
      req1_err   <= err1_nxt;
      req0_rdata <= rdata0_nxt;
      req1_rdata <= rdata1_nxt;
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// tb_apb_arb_master: directed, table-driven bench for apb_arb_master.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_apb_arb_master;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int TO     = 4;

  logic              cpu_clk, cpu_rstn;
  logic              req0_valid, req0_write, req1_valid, req1_write;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;
  logic              req0_done, req0_err, req1_done, req1_err;
  logic [DATA_W-1:0] req0_rdata, req1_rdata;
  logic              psel, penable, pwrite, pready, pslverr;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata;

  apb_arb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
    .req1_err(req1_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    int unsigned req;
    bit          write;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  prdata;
    int unsigned waits;
    bit          slverr;
    logic [7:0]  exp_rdata;
    bit          exp_err;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mdl_rdata [2];
  bit         mdl_err   [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic get_done(input int unsigned r);
    return (r == 1) ? req1_done : req0_done;
  endfunction
  function automatic logic get_err(input int unsigned r);
    return (r == 1) ? req1_err : req0_err;
  endfunction
  function automatic logic [7:0] get_rdata(input int unsigned r);
    return (r == 1) ? req1_rdata : req0_rdata;
  endfunction

  task automatic set_req(input int unsigned r, input bit valid, input vec_t v);
    if (r == 1) begin
      req1_valid = valid; req1_write = v.write; req1_addr = v.addr; req1_wdata = v.wdata;
    end else begin
      req0_valid = valid; req0_write = v.write; req0_addr = v.addr; req0_wdata = v.wdata;
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  // The request is already asserted. The next edge must grant it. This task
  // follows the transfer through completion and then drops valid.
  task automatic serve(input vec_t v);
    int unsigned r = v.req;
    int unsigned o = 1 - v.req;
    step();
    check("grant_psel", psel, 1);
    check("grant_penable", penable, 0);
    check("grant_pwrite", pwrite, v.write);
    check("grant_paddr", paddr, v.addr);
    check("grant_pwdata", pwdata, v.wdata);
    check("grant_done0", req0_done, 0);
    check("grant_done1", req1_done, 0);
    step();
    check("access_penable", penable, 1);
    check("access_psel", psel, 1);
    prdata  = v.prdata;
    pready  = (v.waits == 0);
    pslverr = v.slverr && (v.waits == 0);
    for (int i = 0; i < int'(v.waits); i++) begin
      step();
      check("wait_penable", penable, 1);
      check("wait_paddr", paddr, v.addr);
      check("wait_done", get_done(r), 0);
      if (i == int'(v.waits) - 1) begin
        pready  = 1'b1;
        pslverr = v.slverr;
      end
    end
    step();
    check("cpl_done", get_done(r), 1);
    check("cpl_err", get_err(r), v.exp_err);
    check("cpl_rdata", get_rdata(r), v.exp_rdata);
    check("cpl_psel", psel, 0);
    check("cpl_penable", penable, 0);
    check("cpl_pwrite", pwrite, 0);
    check("cpl_pwdata", pwdata, 0);
    check("cpl_paddr", paddr, v.addr);
    check("other_done", get_done(o), 0);
    check("other_err", get_err(o), mdl_err[o]);
    check("other_rdata", get_rdata(o), mdl_rdata[o]);
    mdl_err[r]   = v.exp_err;
    mdl_rdata[r] = v.exp_rdata;
    set_req(r, 1'b0, v);
    pready  = 1'b0;
    pslverr = 1'b0;
  endtask

  task automatic do_reset();
    cpu_rstn = 1'b0;
    #1;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_done", {req1_done, req0_done}, 0);
    check("rst_err", {req1_err, req0_err}, 0);
    check("rst_rdata", {req1_rdata, req0_rdata}, 0);
    mdl_err   = '{0, 0};
    mdl_rdata = '{8'h00, 8'h00};
    step();
    step();
    cpu_rstn = 1'b1;
  endtask

  vec_t vecs [6];
  vec_t a, b, c;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fields: req, write, addr, wdata, prdata, waits, slverr, exp_rdata, exp_err.
    vecs[0] = '{0, 1, 8'h01, 8'hA5, 8'h00, 0, 0, 8'h00, 0};
    vecs[1] = '{1, 0, 8'h02, 8'h00, 8'h3C, 2, 0, 8'h3C, 0};
    vecs[2] = '{0, 1, 8'h10, 8'h55, 8'hEE, 0, 1, 8'h00, 1};
    vecs[3] = '{0, 0, 8'h20, 8'h00, 8'h77, 1, 0, 8'h77, 0};
    vecs[4] = '{1, 1, 8'h30, 8'h0F, 8'hEE, 1, 1, 8'h3C, 1};
    vecs[5] = '{1, 0, 8'hFF, 8'h00, 8'hC3, 0, 0, 8'hC3, 0};

    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
    prdata = '0; pready = 0; pslverr = 0;
    cpu_rstn = 1'b1;
    #2;
    do_reset();
    step();

    // Single-requester transfers covering writes, reads, wait states and slave errors.
    foreach (vecs[k]) begin
      set_req(vecs[k].req, 1'b1, vecs[k]);
      serve(vecs[k]);
      step();
      check("gap_psel", psel, 0);
      check("gap_done", get_done(vecs[k].req), 0);
    end

    // Simultaneous requests after reset: requester 0 is served first, then requester 1.
    do_reset();
    step();
    a = '{0, 0, 8'h00, 8'h00, 8'h5A, 0, 0, 8'h5A, 0};
    b = '{1, 1, 8'h01, 8'h80, 8'hEE, 1, 0, 8'h00, 0};
    set_req(0, 1'b1, a);
    set_req(1, 1'b1, b);
    serve(a);
    serve(b);
    step();

    // After requester 0 is served alone, a tie must go to requester 1.
    c = '{0, 0, 8'h04, 8'h00, 8'h21, 0, 0, 8'h21, 0};
    set_req(0, 1'b1, c);
    serve(c);
    step();
    a = '{0, 1, 8'h06, 8'h99, 8'h00, 0, 0, 8'h21, 0};
    b = '{1, 0, 8'h05, 8'h00, 8'h42, 0, 0, 8'h42, 0};
    set_req(0, 1'b1, a);
    set_req(1, 1'b1, b);
    serve(b);
    serve(a);
    step();

    // Reset while ACCESS waits on pready: the transfer aborts with no done pulse.
    a = '{0, 0, 8'h07, 8'h00, 8'h11, 0, 0, 8'h00, 0};
    set_req(0, 1'b1, a);
    step();
    step();
    step();
    check("pre_rst_penable", penable, 1);
    cpu_rstn = 1'b0;
    #1;
    check("midrst_psel", psel, 0);
    check("midrst_penable", penable, 0);
    check("midrst_done", req0_done, 0);
    set_req(0, 1'b0, a);
    mdl_err   = '{0, 0};
    mdl_rdata = '{8'h00, 8'h00};
    step();
    step();
    check("midrst_nodone", req0_done, 0);
    cpu_rstn = 1'b1;
    step();
    b = '{1, 0, 8'h08, 8'h00, 8'h6B, 1, 0, 8'h6B, 0};
    set_req(1, 1'b1, b);
    serve(b);
    step();

    // A read whose pready stays low.
    prdata = 8'h99;
    a = '{0, 0, 8'h09, 8'h00, 8'h99, 0, 0, 8'h00, 0};
    set_req(0, 1'b1, a);
    step();
    check("to_psel", psel, 1);
    step();
    check("to_penable", penable, 1);
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      step();
      check("to_wait_done", req0_done, 0);
    end
    step();
    check("to_done", req0_done, 1);
    check("to_err", req0_err, 1);
    check("to_rdata", req0_rdata, 8'h00);
    check("to_psel_low", psel, 0);
    set_req(0, 1'b0, a);
`else
    begin
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (req0_done) seen = 1;
      end
      check("no_timeout_done", seen, 0);
      check("no_timeout_penable", penable, 1);
    end
    set_req(0, 1'b0, a);
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
